// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the data cache refill path: one request at a time,
// line reads as LINE_WORDS ascending beats, byte-strobed word writes, fixed access latency.

module cache_mem_responder_lane (
    input  logic       en,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = en ? new_byte : old_byte;
endmodule

module cache_mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        busy
);
    localparam int NUM_LANES = 4;
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] WACK = 2'd3;

    typedef struct packed {
        logic                 write;
        logic [AW-1:0]        idx;
        logic [31:0]          wdata;
        logic [NUM_LANES-1:0] wstrb;
    } req_t;

    logic [1:0]    state;
    req_t          req_q;
    logic [CW-1:0] lat_cnt;
    logic [BW-1:0] beat;

    // Storage is deliberately outside reset; zero start keeps simulation X-free.
    logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS] = '{default: '0};

    logic                      lat_done;
    logic                      commit;
    logic [AW-1:0]             rd_idx;
    logic [NUM_LANES-1:0][7:0] old_word;
    logic [NUM_LANES-1:0][7:0] new_word;
    logic [NUM_LANES-1:0][7:0] wr_word;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign lat_done = (lat_cnt == '0);
    assign commit   = (state == WAIT) && lat_done && req_q.write;
    assign rd_idx   = (req_q.idx & ~AW'(LINE_WORDS - 1)) | AW'(beat);
    assign old_word = mem[req_q.idx];
    assign new_word = req_q.wdata;

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            cache_mem_responder_lane u_lane (
                .en       (req_q.wstrb[l]),
                .old_byte (old_word[l]),
                .new_byte (new_word[l]),
                .merged   (wr_word[l])
            );
        end
    endgenerate

    // Write lands on the edge entering WACK, so the ack implies visibility.
    always_ff @(posedge clk) begin
        if (commit) mem[req_q.idx] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            req_q   <= '0;
            lat_cnt <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_q.write <= req_write;
                    req_q.idx   <= req_addr[AW+1:2];
                    req_q.wdata <= req_wdata;
                    req_q.wstrb <= req_wstrb;
                    lat_cnt     <= CW'(LATENCY - 1);
                    beat        <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (lat_done) state <= req_q.write ? WACK : RESP;
                    else          lat_cnt <= lat_cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    if (beat == BW'(LINE_WORDS - 1)) state <= IDLE;
                    beat <= beat + 1'b1;
                end
                WACK: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP) || (state == WACK);
    assign resp_last  = (state == WACK) || ((state == RESP) && (beat == BW'(LINE_WORDS - 1)));
    assign resp_data  = (state == RESP) ? mem[rd_idx] : '0;

endmodule
